// File: rtl/ifetch_unit.sv
// Instruction fetch stage: PC register, combinational imem access,
// and a small in-order FIFO of {pc, instr} pairs towards decode.
module ifetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     fetch_en,
    input  logic                     redirect_valid,
    input  logic [31:0]              redirect_pc,
    output logic [31:0]              iaddr,
    input  logic [31:0]              idata,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [31:0]              out_pc,
    output logic [31:0]              out_instr,
    output logic [$clog2(DEPTH):0]   out_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [31:0]   pc;
    logic [31:0]   pc_mem    [DEPTH];
    logic [31:0]   instr_mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [CW-1:0] count;
    logic          deq;
    logic          space;
    logic          fetch;
    logic          unused_bits;

    // Low target bits are forced to zero, so they never reach the PC.
    assign unused_bits = ^redirect_pc[1:0];

    assign iaddr     = pc;
    assign out_valid = (count != '0);
    assign out_pc    = pc_mem[rd_ptr];
    assign out_instr = instr_mem[rd_ptr];
    assign out_count = count;

    // A slot frees up in the same cycle the head is accepted.
    assign deq   = out_valid & out_ready;
    assign space = (count < CW'(DEPTH)) | deq;
    assign fetch = fetch_en & space & ~redirect_valid;

    // Program counter: reset, redirect, or advance after each enqueue.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc <= RESET_PC;
        end else if (redirect_valid) begin
            pc <= {redirect_pc[31:2], 2'b00};
        end else if (fetch) begin
            pc <= pc + 32'd4;
        end
    end

    // FIFO pointers and occupancy; a redirect empties the buffer.
    always_ff @(posedge clk) begin
        if (rst || redirect_valid) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (fetch) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (deq) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({fetch, deq})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Entry storage; cleared on reset so the idle head reads as zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                pc_mem[i]    <= '0;
                instr_mem[i] <= '0;
            end
        end else if (fetch) begin
            pc_mem[wr_ptr]    <= pc;
            instr_mem[wr_ptr] <= idata;
        end
    end

endmodule

// File: tb/tb_ifetch_unit.sv
// Bench for ifetch_unit: queue-based reference model checked every cycle,
// plus directed scenarios with literal expected values.
module tb_ifetch_unit;

    localparam int          DEPTH    = 2;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        fetch_en;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] iaddr;
    logic [31:0] idata;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
    logic [1:0]  out_count;

    int errors = 0;
    int checks = 0;
    bit armed  = 1'b0;

    logic [31:0] pc_m;
    logic [63:0] q_m[$];

    ifetch_unit #(
        .RESET_PC (RESET_PC),
        .DEPTH    (DEPTH)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .fetch_en       (fetch_en),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .iaddr          (iaddr),
        .idata          (idata),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_pc         (out_pc),
        .out_instr      (out_instr),
        .out_count      (out_count)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] imem(input logic [31:0] a);
        case (a)
            32'h0000_0000: return 32'h0000_0513;
            32'h0000_0004: return 32'h0010_0593;
            32'h0000_0008: return 32'h0020_0613;
            32'h0000_0020: return 32'h02F6_F463;
            default:       return {~a[15:0], a[15:0]} ^ 32'h0013_0000;
        endcase
    endfunction

    assign idata = imem(iaddr);

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: a queue of {pc, instr} and the model PC.
    always @(posedge clk) begin
        bit d;
        bit f;
        if (rst) begin
            pc_m = RESET_PC;
            q_m.delete();
        end else if (redirect_valid) begin
            pc_m = {redirect_pc[31:2], 2'b00};
            q_m.delete();
        end else begin
            d = (q_m.size() > 0) && out_ready;
            f = fetch_en && ((q_m.size() < DEPTH) || d);
            if (d) void'(q_m.pop_front());
            if (f) begin
                q_m.push_back({pc_m, imem(pc_m)});
                pc_m = pc_m + 32'd4;
            end
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (armed) begin
            chk("m_iaddr", iaddr, pc_m);
            chk("m_count", 32'(out_count), 32'(q_m.size()));
            chk("m_valid", 32'(out_valid), 32'(q_m.size() != 0));
            if (q_m.size() != 0) begin
                chk("m_pc", out_pc, q_m[0][63:32]);
                chk("m_instr", out_instr, q_m[0][31:0]);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        fetch_en = 1'b0;
        out_ready = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = '0;
        tick();
        armed = 1'b1;
        chk("rst_iaddr", iaddr, 32'h0);
        chk("rst_count", 32'(out_count), 32'd0);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_pc", out_pc, 32'h0);
        chk("rst_instr", out_instr, 32'h0);

        // Reset-then-stream
        rst = 1'b0;
        fetch_en = 1'b1;
        out_ready = 1'b1;
        tick();
        chk("s0_pc", out_pc, 32'h0);
        chk("s0_instr", out_instr, 32'h0000_0513);
        tick();
        chk("s1_pc", out_pc, 32'h4);
        chk("s1_instr", out_instr, 32'h0010_0593);
        tick();
        chk("s2_pc", out_pc, 32'h8);
        chk("s2_instr", out_instr, 32'h0020_0613);

        // Back-pressure
        rst = 1'b1;
        tick();
        rst = 1'b0;
        out_ready = 1'b0;
        repeat (5) tick();
        chk("bp_count", 32'(out_count), 32'd2);
        chk("bp_iaddr", iaddr, 32'h8);
        chk("bp_pc", out_pc, 32'h0);
        chk("bp_instr", out_instr, 32'h0000_0513);
        out_ready = 1'b1;
        chk("bd0_pc", out_pc, 32'h0);
        tick();
        chk("bd1_pc", out_pc, 32'h4);
        tick();
        chk("bd2_pc", out_pc, 32'h8);

        // Redirect with two entries buffered
        chk("rd_pre_count", 32'(out_count), 32'd2);
        redirect_valid = 1'b1;
        redirect_pc = 32'h0000_0022;
        tick();
        redirect_valid = 1'b0;
        chk("rd_valid", 32'(out_valid), 32'd0);
        chk("rd_iaddr", iaddr, 32'h20);
        tick();
        chk("rd_pc", out_pc, 32'h20);
        chk("rd_instr", out_instr, 32'h02F6_F463);

        // Reset dominates redirect with a full FIFO
        out_ready = 1'b0;
        repeat (2) tick();
        chk("rp_pre_count", 32'(out_count), 32'd2);
        rst = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc = 32'h40;
        tick();
        chk("rp_iaddr", iaddr, RESET_PC);
        chk("rp_count", 32'(out_count), 32'd0);
        chk("rp_valid", 32'(out_valid), 32'd0);
        rst = 1'b0;
        redirect_valid = 1'b0;

        // fetch_en gating
        repeat (2) tick();
        chk("fe_count", 32'(out_count), 32'd2);
        fetch_en = 1'b0;
        out_ready = 1'b1;
        tick();
        chk("fe_d1_pc", out_pc, 32'h4);
        chk("fe_d1_iaddr", iaddr, 32'h8);
        tick();
        chk("fe_d2_valid", 32'(out_valid), 32'd0);
        chk("fe_d2_iaddr", iaddr, 32'h8);
        fetch_en = 1'b1;
        tick();
        chk("fe_res_pc", out_pc, 32'h8);
        chk("fe_res_iaddr", iaddr, 32'hC);

        // PC wrap
        redirect_valid = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        tick();
        redirect_valid = 1'b0;
        chk("wr_iaddr", iaddr, 32'hFFFF_FFFC);
        tick();
        chk("wr0_pc", out_pc, 32'hFFFF_FFFC);
        tick();
        chk("wr1_pc", out_pc, 32'h0);
        tick();
        chk("wr2_pc", out_pc, 32'h4);

        // Mixed directed pattern, checked by the model
        for (int i = 0; i < 60; i++) begin
            out_ready = ((i % 3) != 0);
            fetch_en = ((i % 7) != 3);
            redirect_valid = ((i % 17) == 9);
            redirect_pc = 32'h100 + 32'(i * 8) + 32'd1;
            rst = (i == 40);
            tick();
        end
        rst = 1'b0;
        redirect_valid = 1'b0;
        tick();
        #10;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
